fork_join_ctrl: RTL

FORK_JOIN_CTRL -- requirements
Module: fork_join_ctrl

---
 rtl/fork_join_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches a masked job group and signals when its join policy is met.
// Optional watchdog enabled by defining FJC_TIMEOUT_EN.
module fork_join_ctrl #(
    parameter int unsigned NUM_JOBS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [NUM_JOBS-1:0]         job_en,
    input  logic [NUM_JOBS-1:0]         job_done,
    output logic [NUM_JOBS-1:0]         job_start,
    output logic                        busy,
    output logic                        joined,
    output logic                        all_done,
    output logic [$clog2(NUM_JOBS)-1:0] first_id,
    output logic [NUM_JOBS-1:0]         done_mask,
    output logic                        timeout
);
    localparam int unsigned IDW = $clog2(NUM_JOBS);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DRAIN} state_t;
    typedef enum logic [1:0] {
        JOIN_ALL  = 2'b00,
        JOIN_ANY  = 2'b01,
        JOIN_NONE = 2'b10
    } join_t;

    state_t              state_q;
    join_t               mode_q;
    logic [NUM_JOBS-1:0] mask_q;
    logic [NUM_JOBS-1:0] done_mask_q;
    logic [NUM_JOBS-1:0] done_mask_d;
    logic [NUM_JOBS-1:0] job_start_q;
    logic [IDW-1:0]      first_id_q;
    logic                joined_q;
    logic                all_done_q;
    logic                joined_flag_q;
    logic [NUM_JOBS-1:0] new_done;
    logic [IDW-1:0]      new_id;
    logic                complete;
    logic                join_hit;
    logic                to_hit;
    join_t               mode_in;

`ifdef FJC_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
`endif

    always_comb begin
        new_done    = job_done & mask_q & ~done_mask_q;
        done_mask_d = done_mask_q | new_done;
        complete    = (done_mask_d == mask_q);
        new_id      = '0;
        // Scan from the top so the lowest set index wins.
        for (int unsigned i = 0; i < NUM_JOBS; i++) begin
            if (new_done[NUM_JOBS-1-i]) new_id = IDW'(NUM_JOBS - 1 - i);
        end
        join_hit = !joined_flag_q &&
                   (((mode_q == JOIN_NONE) && (state_q == LAUNCH)) ||
                    ((mode_q == JOIN_ANY) && (new_done != '0)));
`ifdef FJC_TIMEOUT_EN
        to_hit = (state_q != LAUNCH) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
        to_hit = 1'b0;
`endif
        case (mode)
            2'b01:   mode_in = JOIN_ANY;
            2'b10:   mode_in = JOIN_NONE;
            default: mode_in = JOIN_ALL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mode_q        <= JOIN_ALL;
            mask_q        <= '0;
            done_mask_q   <= '0;
            job_start_q   <= '0;
            first_id_q    <= '0;
            joined_q      <= 1'b0;
            all_done_q    <= 1'b0;
            joined_flag_q <= 1'b0;
`ifdef FJC_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            job_start_q <= '0;
            joined_q    <= 1'b0;
            all_done_q  <= 1'b0;
`ifdef FJC_TIMEOUT_EN
            timeout_q   <= 1'b0;
            if (state_q != IDLE) cnt_q <= cnt_q + 1'b1;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q        <= mode_in;
                        mask_q        <= job_en;
                        done_mask_q   <= '0;
                        first_id_q    <= '0;
                        joined_flag_q <= 1'b0;
`ifdef FJC_TIMEOUT_EN
                        cnt_q         <= '0;
`endif
                        if (job_en == '0) begin
                            joined_q   <= 1'b1;
                            all_done_q <= 1'b1;
                        end else begin
                            job_start_q <= job_en;
                            state_q     <= LAUNCH;
                        end
                    end
                end
                default: begin
                    done_mask_q <= done_mask_d;
                    if ((done_mask_q == '0) && (new_done != '0)) first_id_q <= new_id;
                    // Completion outranks the watchdog, which outranks a plain join.
                    if (complete) begin
                        all_done_q <= 1'b1;
                        joined_q   <= !joined_flag_q;
                        state_q    <= IDLE;
                    end else if (to_hit) begin
`ifdef FJC_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                        joined_q  <= !joined_flag_q;
                        state_q   <= IDLE;
                    end else if (join_hit) begin
                        joined_q      <= 1'b1;
                        joined_flag_q <= 1'b1;
                        state_q       <= DRAIN;
                    end else if (state_q == LAUNCH) begin
                        state_q <= WAIT;
                    end
                end
            endcase
        end
    end

    assign job_start = job_start_q;
    assign busy      = (state_q != IDLE);
    assign joined    = joined_q;
    assign all_done  = all_done_q;
    assign first_id  = first_id_q;
    assign done_mask = done_mask_q;
`ifdef FJC_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule
